// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order reorder buffer.
// Takes up to MACHINE_WIDTH renamed instructions per cycle and hands back their
// ROB indices combinationally. FU writebacks mark entries complete. Up to
// MACHINE_WIDTH completed entries retire per cycle, in program order.
// Ports:
//   clk, resetn               clock, async active-low reset
//   alloc_*                   allocation group from rename; alloc_ready, rob_addr back
//   wb_*                      FU_NUM writeback ports (complete + exception)
//   commit_*                  per-lane retirement view (combinational from state)
//   flush                     synchronous discard of all entries
module reorder_buffer #(
    parameter int unsigned MACHINE_WIDTH = 2,
    parameter int unsigned ROB_DEPTH     = 16,
    parameter int unsigned FU_NUM        = 4,
    parameter int unsigned PREG_W        = 6,
    parameter int unsigned AREG_W        = 5,
    parameter int unsigned ROB_AW        = $clog2(ROB_DEPTH)
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [MACHINE_WIDTH-1:0]          alloc_valid,
    output logic                              alloc_ready,
    input  logic [MACHINE_WIDTH-1:0]          alloc_has_dst,
    input  logic [MACHINE_WIDTH*AREG_W-1:0]   alloc_dst_areg,
    input  logic [MACHINE_WIDTH*PREG_W-1:0]   alloc_dst_preg,
    input  logic [MACHINE_WIDTH*PREG_W-1:0]   alloc_old_preg,
    input  logic [MACHINE_WIDTH*32-1:0]       alloc_pc,
    output logic [MACHINE_WIDTH*ROB_AW-1:0]   rob_addr,
    input  logic [FU_NUM-1:0]                 wb_valid,
    input  logic [FU_NUM*ROB_AW-1:0]          wb_rob_addr,
    input  logic [FU_NUM-1:0]                 wb_exception,
    output logic [MACHINE_WIDTH-1:0]          commit_valid,
    output logic [MACHINE_WIDTH-1:0]          commit_has_dst,
    output logic [MACHINE_WIDTH*AREG_W-1:0]   commit_dst_areg,
    output logic [MACHINE_WIDTH*PREG_W-1:0]   commit_dst_preg,
    output logic [MACHINE_WIDTH*PREG_W-1:0]   commit_old_preg,
    output logic [MACHINE_WIDTH*32-1:0]       commit_pc,
    output logic                              commit_exception,
    input  logic                              flush
);

    localparam int unsigned CNT_W = ROB_AW + 1;

    // Per-entry state
    logic [ROB_DEPTH-1:0] valid_q, complete_q, exc_q, has_dst_q;
    logic [AREG_W-1:0]    areg_q     [ROB_DEPTH];
    logic [PREG_W-1:0]    preg_q     [ROB_DEPTH];
    logic [PREG_W-1:0]    old_preg_q [ROB_DEPTH];
    logic [31:0]          pc_q       [ROB_DEPTH];

    logic [ROB_AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              alloc_fire;
    logic              commit_open;
    logic [CNT_W-1:0]  n_alloc, n_retire;
    logic [ROB_AW-1:0] alloc_idx  [MACHINE_WIDTH];
    logic [ROB_AW-1:0] commit_idx [MACHINE_WIDTH];

    // Readiness looks only at registered occupancy; same-cycle retirement is not credited
    assign alloc_ready = (CNT_W'(ROB_DEPTH) - count_q) >= CNT_W'(MACHINE_WIDTH);
    assign alloc_fire  = alloc_ready & (|alloc_valid);

    // Compacted lane indices: each valid lane takes the next free slot after tail
    always_comb begin : alloc_index
        n_alloc  = '0;
        rob_addr = '0;
        for (int unsigned i = 0; i < MACHINE_WIDTH; i++) begin
            alloc_idx[i] = tail_q + ROB_AW'(n_alloc);
            rob_addr[i*ROB_AW +: ROB_AW] = alloc_idx[i];
            if (alloc_valid[i]) n_alloc = n_alloc + CNT_W'(1);
        end
    end

    // In-order retirement; an excepting entry only ever retires alone on lane 0
    always_comb begin : commit_select
        commit_valid     = '0;
        commit_has_dst   = '0;
        commit_dst_areg  = '0;
        commit_dst_preg  = '0;
        commit_old_preg  = '0;
        commit_pc        = '0;
        commit_exception = 1'b0;
        n_retire         = '0;
        commit_open      = 1'b1;
        for (int unsigned i = 0; i < MACHINE_WIDTH; i++) begin
            commit_idx[i] = head_q + ROB_AW'(i);
            if (commit_open && valid_q[commit_idx[i]] && complete_q[commit_idx[i]]
                && ((i == 0) || !exc_q[commit_idx[i]])) begin
                commit_valid[i]                    = 1'b1;
                commit_has_dst[i]                  = has_dst_q[commit_idx[i]];
                commit_dst_areg[i*AREG_W +: AREG_W] = areg_q[commit_idx[i]];
                commit_dst_preg[i*PREG_W +: PREG_W] = preg_q[commit_idx[i]];
                commit_old_preg[i*PREG_W +: PREG_W] = old_preg_q[commit_idx[i]];
                commit_pc[i*32 +: 32]              = pc_q[commit_idx[i]];
                n_retire                           = n_retire + CNT_W'(1);
            end else begin
                commit_open = 1'b0;
            end
            // nothing younger than an exception may retire alongside it
            if (exc_q[commit_idx[i]]) commit_open = 1'b0;
        end
        commit_exception = commit_valid[0] & exc_q[head_q];
    end

    // Pointer and occupancy update
    always_comb begin : ptr_next
        head_d  = head_q + ROB_AW'(n_retire);
        tail_d  = alloc_fire ? (tail_q + ROB_AW'(n_alloc)) : tail_q;
        count_d = count_q + (alloc_fire ? n_alloc : '0) - n_retire;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Entry state: writeback, then retirement clear, then allocation (disjoint slots)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            complete_q <= '0;
            exc_q      <= '0;
            has_dst_q  <= '0;
            for (int unsigned e = 0; e < ROB_DEPTH; e++) begin
                areg_q[e]     <= '0;
                preg_q[e]     <= '0;
                old_preg_q[e] <= '0;
                pc_q[e]       <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (flush) begin
                valid_q    <= '0;
                complete_q <= '0;
                exc_q      <= '0;
            end else begin
                for (int unsigned k = 0; k < FU_NUM; k++) begin
                    if (wb_valid[k] && valid_q[wb_rob_addr[k*ROB_AW +: ROB_AW]]) begin
                        complete_q[wb_rob_addr[k*ROB_AW +: ROB_AW]] <= 1'b1;
                        if (wb_exception[k]) exc_q[wb_rob_addr[k*ROB_AW +: ROB_AW]] <= 1'b1;
                    end
                end
                for (int unsigned i = 0; i < MACHINE_WIDTH; i++) begin
                    if (commit_valid[i]) begin
                        valid_q[commit_idx[i]]    <= 1'b0;
                        complete_q[commit_idx[i]] <= 1'b0;
                        exc_q[commit_idx[i]]      <= 1'b0;
                    end
                end
                if (alloc_fire) begin
                    for (int unsigned i = 0; i < MACHINE_WIDTH; i++) begin
                        if (alloc_valid[i]) begin
                            valid_q[alloc_idx[i]]    <= 1'b1;
                            complete_q[alloc_idx[i]] <= 1'b0;
                            exc_q[alloc_idx[i]]      <= 1'b0;
                            has_dst_q[alloc_idx[i]]  <= alloc_has_dst[i];
                            areg_q[alloc_idx[i]]     <= alloc_dst_areg[i*AREG_W +: AREG_W];
                            preg_q[alloc_idx[i]]     <= alloc_dst_preg[i*PREG_W +: PREG_W];
                            old_preg_q[alloc_idx[i]] <= alloc_old_preg[i*PREG_W +: PREG_W];
                            pc_q[alloc_idx[i]]       <= alloc_pc[i*32 +: 32];
                        end
                    end
                end
            end
        end
    end

endmodule
